// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline constants and the fetch FSM state type.
package pipeline_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_cycle_if.sv
// fetch_cycle_if: instruction-memory request/response bus, one outstanding request.
interface fetch_cycle_if;
   import pipeline_pkg::*;
   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic            rvalid;
   logic [XLEN-1:0] rdata;
   modport master(output req, addr, input ready, rvalid, rdata);
   modport slave(input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_if_id_reg.sv
// fetch_if_id_reg: IF/ID pipeline register with reset > flush > stall > load > idle priority.
module fetch_if_id_reg
   import pipeline_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            stall,
   input  logic            load,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] inst_in,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] inst,
   output logic            vld
);
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pc   <= '0;
         inst <= NOP_INST;
         vld  <= 1'b0;
      end else if (!stall) begin
         pc   <= load ? pc_in : pc;
         inst <= load ? inst_in : NOP_INST;
         vld  <= load;
      end
   end
endmodule

// File: rtl/fetch_cycle.sv
// fetch_cycle: IF stage owning the PC, fetching from variable-latency imem and feeding IF/ID.
module fetch_cycle
   import pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            i_fetch_clk,
   input  logic            i_fetch_reset,
   input  logic            i_fetch_pc_sel,
   input  logic [XLEN-1:0] i_fetch_alu_data,
   input  logic            i_fetch_stall,
   input  logic            i_fetch_flush,
   fetch_cycle_if.master   imem,
   output logic [XLEN-1:0] o_fetch_pc_de,
   output logic [XLEN-1:0] o_fetch_inst_de,
   output logic            o_fetch_vld_de
);
   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, hold_q, hold_d, tgt, pc_inc, issue_addr, deliver_inst;
   logic            issue, deliver;

   assign tgt    = {i_fetch_alu_data[XLEN-1:2], 2'b00};
   assign pc_inc = pc_q + XLEN'(4);

   // pc_q always tracks the oldest undelivered address, so any issue rewrites it
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_d       = hold_q;
      issue        = 1'b0;
      issue_addr   = pc_q;
      deliver      = 1'b0;
      deliver_inst = imem.rdata;
      case (state_q)
         S_REQ: begin
            issue      = 1'b1;
            issue_addr = i_fetch_pc_sel ? tgt : pc_q;
         end
         S_WAIT: begin
            if (imem.rvalid) begin
               issue      = i_fetch_pc_sel || !i_fetch_stall;
               issue_addr = i_fetch_pc_sel ? tgt : pc_inc;
               deliver    = !i_fetch_pc_sel && !i_fetch_stall;
               hold_d     = (!i_fetch_pc_sel && i_fetch_stall) ? imem.rdata : hold_q;
               state_d    = (!i_fetch_pc_sel && i_fetch_stall) ? S_HOLD : state_q;
            end else if (i_fetch_pc_sel) begin
               pc_d    = tgt;
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            issue      = imem.rvalid;
            issue_addr = i_fetch_pc_sel ? tgt : pc_q;
            pc_d       = i_fetch_pc_sel ? tgt : pc_q;
         end
         S_HOLD: begin
            issue        = i_fetch_pc_sel || !i_fetch_stall;
            issue_addr   = i_fetch_pc_sel ? tgt : pc_inc;
            deliver      = !i_fetch_pc_sel && !i_fetch_stall;
            deliver_inst = hold_q;
         end
         default: state_d = S_REQ;
      endcase
      if (issue) begin
         pc_d    = issue_addr;
         state_d = imem.ready ? S_WAIT : S_REQ;
      end
   end

   always_ff @(posedge i_fetch_clk) begin
      if (i_fetch_reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   assign imem.req  = issue && !i_fetch_reset;
   assign imem.addr = issue_addr;

   fetch_if_id_reg u_if_id (
      .clk    (i_fetch_clk),
      .rst    (i_fetch_reset),
      .flush  (i_fetch_flush),
      .stall  (i_fetch_stall),
      .load   (deliver),
      .pc_in  (pc_q),
      .inst_in(deliver_inst),
      .pc     (o_fetch_pc_de),
      .inst   (o_fetch_inst_de),
      .vld    (o_fetch_vld_de)
   );
endmodule

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle: directed table, corner sequences and random traffic against a stream-level model.
module tb_fetch_cycle;
   import pipeline_pkg::*;

   typedef struct {
      logic        stall;
      logic        pc_sel;
      logic        flush;
      logic [31:0] alu;
      logic        exp_vld;
      logic [31:0] exp_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, pc_sel, stall, flush;
   logic [31:0] alu, pc_de, inst_de;
   logic        vld_de;

   always #5 clk = ~clk;

   fetch_cycle_if imem();

   fetch_cycle #(.RESET_PC(32'h0)) dut (
      .i_fetch_clk     (clk),
      .i_fetch_reset   (rst),
      .i_fetch_pc_sel  (pc_sel),
      .i_fetch_alu_data(alu),
      .i_fetch_stall   (stall),
      .i_fetch_flush   (flush),
      .imem            (imem),
      .o_fetch_pc_de   (pc_de),
      .o_fetch_inst_de (inst_de),
      .o_fetch_vld_de  (vld_de)
   );

   int          n_cmp = 0, n_err = 0, dcount = 0;
   int          wait_cnt, lat_min, lat_max;
   logic        pending, rdy_rand, rdy_off, stale;
   logic [31:0] paddr, exp_pc, last_dpc;
   logic        rst_p, stall_p, flush_p, sel_p;
   logic [31:0] alu_p;
   vec_t        tbl[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h0050_0093;
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Stream-level model: delivered pcs run sequentially from the last redirect target,
   // each carrying its memory word; stalls freeze IF/ID, flush/reset clear it.
   task automatic model(input logic [95:0] snap);
      if (rst_p) begin
         chk("reset_ifid", {vld_de, pc_de, inst_de}, {1'b0, 32'h0, NOP_INST});
         exp_pc = 32'h0;
      end else if (flush_p)
         chk("flush_ifid", {vld_de, pc_de, inst_de}, {1'b0, 32'h0, NOP_INST});
      else if (stall_p)
         chk("stall_hold", {vld_de, pc_de, inst_de}, snap);
      else if (sel_p)
         chk("redirect_no_deliver", vld_de, 0);
      else if (vld_de) begin
         chk("deliver_pc", pc_de, exp_pc);
         chk("deliver_inst", inst_de, mem_word(pc_de));
         exp_pc   = pc_de + 32'd4;
         last_dpc = pc_de;
         dcount++;
      end else
         chk("idle_nop", inst_de, NOP_INST);
      if (sel_p && !rst_p) exp_pc = alu_p & ~32'h3;
   endtask

   task automatic cycle(input logic s, input logic p, input logic f, input logic [31:0] a);
      logic [95:0] snap;
      stall  = s;
      pc_sel = p;
      flush  = f;
      alu    = a;
      imem.ready  = rdy_off ? 1'b0 : rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
      imem.rvalid = 1'b0;
      imem.rdata  = $urandom;
      if (pending) begin
         wait_cnt--;
         if (wait_cnt == 0) begin
            imem.rvalid = 1'b1;
            imem.rdata  = stale ? 32'hDEAD_BEEF : mem_word(paddr);
            pending     = 1'b0;
         end
      end
      #1;
      if (rst) chk("req_in_reset", imem.req, 0);
      if (imem.req && imem.ready) begin
         chk("addr_align", imem.addr[1:0], 0);
         pending  = 1'b1;
         paddr    = imem.addr;
         wait_cnt = $urandom_range(lat_max, lat_min);
      end
      snap    = {vld_de, pc_de, inst_de};
      rst_p   = rst;
      stall_p = s;
      flush_p = f;
      sel_p   = p;
      alu_p   = a;
      @(posedge clk);
      @(negedge clk);
      model(snap);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      pending = 1'b0;
      stale   = 1'b0;
      rdy_off = 1'b0;
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      rst = 1'b0;
   endtask

   task automatic wait_deliv(input string name, input logic [31:0] exp);
      int d0 = dcount;
      for (int i = 0; i < 30 && dcount == d0; i++) cycle(0, 0, 0, 0);
      chk({name, "_seen"}, dcount != d0, 1);
      if (dcount != d0) chk(name, last_dpc, exp);
   endtask

   task automatic add(input logic s, input logic p, input logic f, input logic [31:0] a,
                      input logic ev, input logic [31:0] ep);
      tbl.push_back('{s, p, f, a, ev, ep});
   endtask

   initial begin
      rst = 1'b1; stall = 0; pc_sel = 0; flush = 0; alu = 0;
      imem.ready = 0; imem.rvalid = 0; imem.rdata = 0;
      pending = 0; rdy_rand = 0; rdy_off = 0; stale = 0;
      lat_min = 1; lat_max = 1; exp_pc = 0; last_dpc = 0;
      @(negedge clk);

      // 1-cycle memory, always ready: rows give inputs and IF/ID after that edge
      add(0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 32'h0);
      add(0, 0, 0, 0, 1, 32'h4);
      add(0, 0, 0, 0, 1, 32'h8);
      add(1, 0, 0, 0, 1, 32'h8);
      add(1, 0, 0, 0, 1, 32'h8);
      add(1, 0, 0, 0, 1, 32'h8);
      add(0, 0, 0, 0, 1, 32'hC);
      add(0, 0, 0, 0, 1, 32'h10);
      add(0, 1, 1, 32'h100, 0, 0);
      add(0, 0, 0, 0, 1, 32'h100);
      add(0, 1, 0, 32'h43, 0, 0);
      add(0, 0, 0, 0, 1, 32'h40);
      add(1, 1, 0, 32'h200, 1, 32'h40);
      add(0, 0, 0, 0, 1, 32'h200);
      add(0, 1, 1, 32'hFFFF_FFF8, 0, 0);
      add(0, 0, 0, 0, 1, 32'hFFFF_FFF8);
      add(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      add(0, 0, 0, 0, 1, 32'h0);
      add(1, 0, 0, 0, 1, 32'h0);
      add(1, 1, 0, 32'h80, 1, 32'h0);
      add(0, 0, 0, 0, 1, 32'h80);
      add(0, 0, 0, 0, 1, 32'h84);
      do_reset();
      foreach (tbl[i]) begin
         cycle(tbl[i].stall, tbl[i].pc_sel, tbl[i].flush, tbl[i].alu);
         chk($sformatf("tbl%0d_vld", i), vld_de, tbl[i].exp_vld);
         if (tbl[i].exp_vld) chk($sformatf("tbl%0d_pc", i), pc_de, tbl[i].exp_pc);
      end

      // redirect to 0x40 while a 4-cycle fetch of 0x10 is in flight
      lat_min = 4; lat_max = 4;
      do_reset();
      cycle(0, 1, 0, 32'h10);
      cycle(0, 1, 0, 32'h40);
      wait_deliv("drop_first_pc", 32'h40);

      // reset while waiting; the stale response arrives after release and must be ignored
      lat_min = 3; lat_max = 3;
      do_reset();
      cycle(0, 0, 0, 0);
      rdy_off = 1'b1;
      rst = 1'b1;
      cycle(0, 0, 0, 0);
      rst   = 1'b0;
      stale = 1'b1;
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      stale   = 1'b0;
      rdy_off = 1'b0;
      wait_deliv("reset_first_pc", 32'h0);

      // random ready, latency, stalls and redirects
      lat_min = 1; lat_max = 4; rdy_rand = 1'b1;
      do_reset();
      dcount = 0;
      for (int i = 0; i < 3000; i++) begin
         logic s, p, f;
         logic [31:0] a;
         s = $urandom_range(99) < 20;
         p = $urandom_range(99) < 6;
         f = p && $urandom_range(1) == 1;
         a = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : 32'($urandom);
         cycle(s, p, f, a);
      end
      chk("random_progress", dcount > 200, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
